// File: rtl/serial_shift_alu.sv
`default_nettype none
// ============================================================================
// Module   : serial_shift_alu
// Purpose  : Execution-stage ALU with valid/ready handshakes on both sides.
//            Logic, arithmetic and compare ops finish in one cycle; shifts
//            are performed one bit per cycle on a serial shifter so that no
//            barrel shifter is needed.
// Revision : 1.0 - initial release
// ============================================================================
module serial_shift_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5    // must equal log2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  // Operation codes produced by the ALU control decoder
  localparam logic [3:0] c_OP_AND  = 4'b0000;
  localparam logic [3:0] c_OP_OR   = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b0010;
  localparam logic [3:0] c_OP_XOR  = 4'b0011;
  localparam logic [3:0] c_OP_SLL  = 4'b0100;
  localparam logic [3:0] c_OP_SRL  = 4'b0101;
  localparam logic [3:0] c_OP_SUB  = 4'b0110;
  localparam logic [3:0] c_OP_SRA  = 4'b0111;
  localparam logic [3:0] c_OP_SLT  = 4'b1000;
  localparam logic [3:0] c_OP_SLTU = 4'b1001;

  // Control states
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic [SHW-1:0] c_CNT_ONE = SHW'(1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_result;   // doubles as the shift accumulator
  logic             r_zero;
  logic [SHW-1:0]   r_cnt;      // remaining shift steps
  logic [3:0]       r_op;       // captured op, selects shift direction/fill

  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_step;
  logic [SHW-1:0]   w_shamt;
  logic             w_is_shift;
  logic             w_start_shift;
  logic             w_slt;
  logic             w_sltu;

  assign w_shamt       = op_b[SHW-1:0];
  assign w_is_shift    = (alu_op == c_OP_SLL) || (alu_op == c_OP_SRL) ||
                         (alu_op == c_OP_SRA);
  // A zero-distance shift is just a pass-through and takes the 1-cycle path
  assign w_start_shift = w_is_shift && (w_shamt != '0);
  assign w_slt         = $signed(op_a) < $signed(op_b);
  assign w_sltu        = op_a < op_b;

  // Single-cycle datapath; shifts yield op_a here (used only for shamt == 0)
  always_comb begin
    w_alu = op_a + op_b;
    case (alu_op)
      c_OP_ADD:  w_alu = op_a + op_b;
      c_OP_SUB:  w_alu = op_a - op_b;
      c_OP_AND:  w_alu = op_a & op_b;
      c_OP_OR:   w_alu = op_a | op_b;
      c_OP_XOR:  w_alu = op_a ^ op_b;
      c_OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_slt};
      c_OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, w_sltu};
      c_OP_SLL,
      c_OP_SRL,
      c_OP_SRA:  w_alu = op_a;
      default:   w_alu = op_a + op_b;   // unlisted codes behave as ADD
    endcase
  end

  // One-bit step of the serial shifter applied to the accumulator
  always_comb begin
    w_step = r_result;
    case (r_op)
      c_OP_SLL: w_step = {r_result[WIDTH-2:0], 1'b0};
      c_OP_SRL: w_step = {1'b0, r_result[WIDTH-1:1]};
      c_OP_SRA: w_step = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
      default:  w_step = r_result;
    endcase
  end

  // Control FSM plus result/zero/counter registers; kill overrides everything
  // except reset, and result/zero simply keep their value when killed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_cnt    <= '0;
      r_op     <= c_OP_ADD;
    end else if (kill) begin
      r_state <= c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_op <= alu_op;
            if (w_start_shift) begin
              r_result <= op_a;
              r_zero   <= (op_a == '0);
              r_cnt    <= w_shamt;
              r_state  <= c_SHIFT;
            end else begin
              r_result <= w_alu;
              r_zero   <= (w_alu == '0);
              r_state  <= c_DONE;
            end
          end
        end
        c_SHIFT: begin
          r_result <= w_step;
          r_zero   <= (w_step == '0);
          r_cnt    <= r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) begin
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == c_IDLE);
  assign out_valid = (r_state == c_DONE);
  assign busy      = (r_state == c_SHIFT) || (r_state == c_DONE);
  assign result    = r_result;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_shift_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_shift_alu
// Purpose  : Directed self-checking bench for serial_shift_alu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_shift_alu;

  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b0110;
  localparam logic [3:0] AND_ = 4'b0000;
  localparam logic [3:0] OR_  = 4'b0001;
  localparam logic [3:0] XOR_ = 4'b0011;
  localparam logic [3:0] SLL  = 4'b0100;
  localparam logic [3:0] SRL  = 4'b0101;
  localparam logic [3:0] SRA  = 4'b0111;
  localparam logic [3:0] SLT  = 4'b1000;
  localparam logic [3:0] SLTU = 4'b1001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_shift_alu #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request and hold it until accepted; returns #1 after the accept edge
  task automatic issue(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) chk({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
    alu_op   = op;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a     = ~a;     // operands must have been captured on the accept edge
    op_b     = ~b;
  endtask

  // Wait for out_valid (checking the busy window), check result, then pop it
  task automatic take(input string tag, input logic [31:0] er, input logic ez,
                      input int elat);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      chk({tag, "_rdy_busy"}, {30'd0, in_ready, busy}, 32'b01);
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, result, er);
    chk({tag, "_zero"}, 32'(zero), 32'(ez));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er, input logic ez,
                     input int elat);
    issue(tag, op, a, b);
    take(tag, er, ez, elat);
  endtask

  initial begin
    logic [31:0] held;
    logic        seen;

    rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    alu_op = 4'd0; op_a = '0; op_b = '0;
    #2;
    chk("reset_flags", {27'd0, in_ready, busy, out_valid, zero, 1'b0}, {27'd0, 5'b10000});
    chk("reset_result", result, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops
    run("add",   ADD,   32'd7,        32'd5,        32'h0000000C, 1'b0, 1);
    run("sub0",  SUB,   32'd5,        32'd5,        32'h00000000, 1'b1, 1);
    run("subm1", SUB,   32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1);
    run("slt",   SLT,   32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1);
    run("sltu",  SLTU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, 1);
    run("dflt",  4'hF,  32'd2,        32'd3,        32'h00000005, 1'b0, 1);
    run("and",   AND_,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1);
    run("or",    OR_,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1);
    run("xor",   XOR_,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1);

    // Serial shifts: latency shamt+1, shamt taken from op_b[4:0] only
    run("sra4",  SRA,   32'h80000000, 32'd4,        32'hF8000000, 1'b0, 5);
    run("sra3p", SRA,   32'h40000000, 32'd3,        32'h08000000, 1'b0, 4);
    run("sll31", SLL,   32'h00000001, 32'd31,       32'h80000000, 1'b0, 32);
    run("srl0",  SRL,   32'h12345678, 32'd0,        32'h12345678, 1'b0, 1);
    run("srlhi", SRL,   32'hFFFFFFFF, 32'h24,       32'h0FFFFFFF, 1'b0, 5);
    run("srlz",  SRL,   32'h00000001, 32'd1,        32'h00000000, 1'b1, 2);

    // Backpressure: result held while out_ready low, new requests ignored
    issue("bp", SRA, 32'h80000000, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_valid", 32'(out_valid), 32'd1);
    held     = result;
    alu_op   = ADD; op_a = 32'd100; op_b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", result, 32'hF8000000);
      chk("bp_flags", {29'd0, in_ready, out_valid, zero}, 32'b010);
    end
    chk("bp_stable", result, held);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {30'd0, in_ready, out_valid}, 32'b10);

    // Kill in IDLE blocks acceptance
    alu_op = ADD; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    chk("kill_idle", {29'd0, in_ready, out_valid, busy}, 32'b100);

    // Kill mid-shift
    issue("kill", SLL, 32'h00000001, 32'd20);
    repeat (5) @(posedge clk);
    #1;
    chk("kill_pre", {30'd0, in_ready, busy}, 32'b01);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_post", {29'd0, in_ready, out_valid, busy}, 32'b100);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("kill_no_out", 32'(seen), 32'd0);
    run("kill_add", ADD, 32'd1, 32'd1, 32'h00000002, 1'b0, 1);

    // Asynchronous reset mid-shift, between clock edges
    issue("arst", SRA, 32'h80000000, 32'd15);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("arst_result", result, 32'h0);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("arst_no_out", 32'(seen), 32'd0);
    run("arst_new", SRA, 32'hF0000000, 32'd2, 32'hFC000000, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_shift_alu.md
Name: serial_shift_alu

Overview:
- Execution-stage ALU that consumes the 4-bit ALU operation code produced by the ALU control decoder, together with two operands.
- Logic and arithmetic ops complete in one cycle.
- Shifts (SLL/SRL/SRA) run on an area-saving serial shifter at one bit per cycle.
- Valid/ready handshakes on both sides let the control path stall around the variable latency.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request.
- alu_op  input  4  operation code: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101, SRA 0111, SLT 1000, SLTU 1001.
- op_a  input  WIDTH  operand A; the value shifted for shifts.
- op_b  input  WIDTH  operand B; shift amount is op_b[SHW-1:0].
- kill  input  1  synchronous abort (pipeline flush).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  registered; 1 when result == 0.
- busy  output  1  1 in SHIFT or DONE.

Behaviour:
- Reset: async assert on rst_n low, in any state and at any time. Forces:
  - state IDLE, result 0, zero 0, out_valid 0, shift counter 0;
  - in_ready 1 and busy 0 (both decoded from state).
  - A shift in progress is discarded; nothing is emitted after reset.
- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- Accept: on the edge with in_valid && in_ready && !kill, operands and alu_op are captured.
- Non-shift ops: the result is computed and registered on the accept edge; IDLE -> DONE. out_valid is high the next cycle (latency 1).
- Non-shift arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
  - SLT is a signed compare, SLTU unsigned. The result is 1 or 0, zero-extended.
- Unlisted alu_op codes execute as ADD.
- Shift ops with shamt == 0: result = op_a; IDLE -> DONE (latency 1).
- Shift ops with shamt > 0:
  - Accept edge loads the accumulator with op_a and the counter with shamt; IDLE -> SHIFT.
  - Each SHIFT edge shifts the accumulator one bit and decrements the counter:
    - SLL: left, fill 0.
    - SRL: right, fill 0.
    - SRA: right, fill the MSB.
  - The edge where the counter goes 1 -> 0 moves to DONE.
  - out_valid is first high shamt+1 cycles after the accept edge. Maximum latency is 2^SHW cycles.
- DONE:
  - result and zero are held stable while out_valid && !out_ready.
  - On the out_valid && out_ready edge: DONE -> IDLE.
  - Throughput: one op per 2 cycles minimum; no accept while in DONE.
- kill (synchronous, highest priority after reset):
  - From SHIFT or DONE: the next edge returns to IDLE and drops out_valid; no handshake is required.
  - In IDLE with in_valid: the request is not accepted.
  - result/zero keep their last values; they are don't-care while out_valid is 0.
- Simultaneous events:
  - kill && out_ready in DONE: treated as kill.
  - in_valid is ignored outside IDLE; the requester must hold the request until in_ready.
- zero is updated on the same edge as result.

Test Plan:
- ADD/SUB/zero: ADD 7+5 -> result 0x0000000C, zero 0, out_valid 1 cycle after accept. Then SUB 5-5 -> result 0, zero 1. SUB 0-1 -> 0xFFFFFFFF.
- Compares: SLT a=0xFFFFFFFF, b=1 -> 1. SLTU with the same operands -> 0. Code 1111 with a=2, b=3 -> 5 (default ADD).
- Serial shift timing: SRA a=0x80000000, b=4 -> 0xF8000000. Check in_ready=0 and busy=1 for the whole shift, and out_valid first high 5 cycles after accept. SLL a=1, b=31 -> 0x80000000 at 32 cycles. SRL b=0 -> a after 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result/zero stable, in_ready 0. out_ready=1 -> IDLE the next cycle, in_ready 1.
- Kill mid-shift: SLL b=20, assert kill on cycle 6 -> IDLE next cycle, out_valid never asserts. A following ADD 1+1 returns 2 with latency 1.
- Async reset mid-shift: drop rst_n during SRA b=15 with no clock edge -> immediate out_valid 0, result 0, in_ready 1. After release, a new request completes normally.
